// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit parallel register with load/clear and multi-step
// shift/rotate commands, serial in/out, busy status and a done pulse.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] pi,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] po,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {LOAD, SHL, SHR, ROL, ROR, ASR, CLEAR, NOP} op_e;
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e           state_q, state_d;
  op_e              op_q, op_d, cop;
  logic [WIDTH-1:0] po_q, po_d, step;
  logic [AMT_W-1:0] count_q, count_d;
  logic             done_q, done_d, multi;
  assign cop = op_e'(cmd_op);
  always_comb begin
    step = op_q == SHL ? {po_q[WIDTH-2:0], sin_r} :
           op_q == SHR ? {sin_l, po_q[WIDTH-1:1]} :
           op_q == ROL ? {po_q[WIDTH-2:0], po_q[WIDTH-1]} :
           op_q == ROR ? {po_q[0], po_q[WIDTH-1:1]} :
                         {po_q[WIDTH-1], po_q[WIDTH-1:1]};
    multi = cop >= SHL && cop <= ASR && cmd_amt != '0;
    po_d = po_q;
    state_d = state_q;
    op_d = op_q;
    count_d = count_q;
    done_d = 1'b0;
    if (state_q == SHIFT) begin
      po_d = step;
      count_d = count_q - AMT_W'(1);
      state_d = count_q == AMT_W'(1) ? IDLE : SHIFT;
      done_d = count_q == AMT_W'(1);
    end else if (cmd_valid) begin
      po_d = cop == LOAD ? pi : cop == CLEAR ? '0 : po_q;
      state_d = multi ? SHIFT : IDLE;
      op_d = cop;
      // Amounts beyond WIDTH are clamped so rotates come full circle.
      count_d = !multi ? '0 : cmd_amt > AMT_W'(WIDTH) ? AMT_W'(WIDTH) : cmd_amt;
      done_d = !multi;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      po_q <= '0;
      state_q <= IDLE;
      op_q <= NOP;
      count_q <= '0;
      done_q <= 1'b0;
    end else begin
      po_q <= po_d;
      state_q <= state_d;
      op_q <= op_d;
      count_q <= count_d;
      done_q <= done_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q == SHIFT;
  assign done = done_q;
  assign po = po_q;
  assign sout_msb = po_q[WIDTH-1];
  assign sout_lsb = po_q[0];
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor of the team's 4-bit PIPO register.
- Holds a WIDTH-bit register with a parallel input and a parallel output.
- Adds a command interface: load, clear, and multi-step shift/rotate with serial in/out ports, busy status and a done pulse.
- Used as a datapath staging register and as a serialiser/deserialiser front-end.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- AMT_W, $clog2(WIDTH+1), width of the shift-amount field.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  3  0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6 CLEAR, 7 NOP
- cmd_amt  in  AMT_W  shift/rotate step count (ignored for LOAD/CLEAR/NOP)
- pi  in  WIDTH  parallel load data
- sin_r  in  1  serial input entering the LSB on SHL
- sin_l  in  1  serial input entering the MSB on SHR
- po  out  WIDTH  register contents
- sout_msb  out  1  po[WIDTH-1], direct from register
- sout_lsb  out  1  po[0], direct from register
- busy  out  1  high in SHIFT state
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - rst sampled at posedge clk has priority over everything.
  - po=0, state=IDLE, count=0, done=0, busy=0, cmd_ready=1.
  - A reset during SHIFT aborts the operation: no done pulse, po=0.
- Handshake:
  - A command is accepted at an edge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE).
  - The cmd_* fields and pi are sampled only at the accept edge.
- Single-cycle ops (LOAD, CLEAR, NOP, or any shift op with cmd_amt==0):
  - At the accept edge, LOAD sets po<=pi, CLEAR sets po<=0, and NOP and amt==0 leave po unchanged.
  - done=1 for exactly the next cycle; state stays IDLE.
- Multi-step ops (SHL/SHR/ROL/ROR/ASR with cmd_amt>=1):
  - At the accept edge: op latched; count<=min(cmd_amt, WIDTH); state->SHIFT; po unchanged.
  - Each edge in SHIFT performs one 1-bit step and decrements count.
  - When the step with count==1 executes: state->IDLE and done=1 for the next cycle.
  - An accept at edge k with amount n yields po fully updated after edge k+n.
  - busy is high and cmd_ready low from after edge k until after edge k+n.
- Step definitions:
  - SHL: po<={po[WIDTH-2:0], sin_r}
  - SHR: po<={sin_l, po[WIDTH-1:1]}
  - ROL: po<={po[WIDTH-2:0], po[WIDTH-1]}
  - ROR: po<={po[0], po[WIDTH-1:1]}
  - ASR: po<={po[WIDTH-1], po[WIDTH-1:1]}
  - sin_r/sin_l are sampled at every step edge, not latched at accept.
- Clamp: cmd_amt>WIDTH is treated as WIDTH, so SHL/SHR fully replace the contents with serial input and rotates return to the original value.
- Back-to-back: a new command may be accepted in the same cycle done is high, because state is already IDLE.
- cmd_valid while busy is ignored (not queued). The upstream holds cmd_valid until cmd_ready.
- Outputs are all registered or derived directly from registered state. No combinational path from inputs to outputs.

Test Plan:
- Reset: drive pi=8'hFF and LOAD, then assert rst -> po=8'h00, cmd_ready=1, done=0 on the next cycle.
- LOAD: cmd LOAD, pi=8'hA5 -> po=8'hA5 one edge later; done high exactly one cycle; busy never high.
- SHL with serial input: from 8'hA5, SHL amt=3 with sin_r=1,0,1 on the successive step edges -> po=8'h2D after edge k+3; cmd_ready low for 3 cycles; single done pulse.
- Rotate clamp: from 8'h81, ROR amt=15 -> clamped to 8 steps, po=8'h81, busy for 8 cycles. ROL amt=1 then gives 8'h03.
- ASR and amt=0: from 8'h90, ASR amt=2 -> 8'hE4. SHR amt=0 -> po unchanged, done next cycle, no busy.
- Mid-op reset and busy rejection: start SHR amt=6 and assert cmd_valid with LOAD while busy -> LOAD ignored. Assert rst at step 3 -> po=0, no done, cmd_ready=1. A LOAD accepted in the done cycle of a completed op takes effect.
